// File: rtl/end_screen_ctrl.sv
`default_nettype none
//============================================================================
// Module      : end_screen_ctrl
// Description : End-of-game overlay sequencer. It latches a LOSE or WIN
//               outcome from the snake logic and freezes gameplay while the
//               end screen is shown. The GAME OVER / YOU WIN overlay enables
//               blink on frame ticks. After a hold-off period, a fresh press
//               of the restart button generates a one-cycle restart pulse.
// Ports       : pclk         - pixel clock
//               rst          - asynchronous reset, active-high
//               vsync_in     - vsync; each rising edge is one frame tick
//               collision    - snake hit wall/self (level or pulse)
//               win          - snake reached max length (level or pulse)
//               restart_btn  - synchronized, debounced button level
//               game_over    - GAME OVER overlay enable (blink-gated)
//               victory      - YOU WIN overlay enable (blink-gated)
//               game_frozen  - halts snake movement and food generation
//               game_restart - one-cycle pulse to reinitialize the game
//               state        - current state code (debug/LED)
// Revision    : 1.0 - initial release
//============================================================================
module end_screen_ctrl #(
    parameter int BLINK_FRAMES   = 30,
    parameter int HOLDOFF_FRAMES = 60,
    parameter int CNT_W          = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       collision,
    input  logic       win,
    input  logic       restart_btn,
    output logic       game_over,
    output logic       victory,
    output logic       game_frozen,
    output logic       game_restart,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_PLAY    = 2'd0,
        S_LOSE    = 2'd1,
        S_WIN     = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    // A blink period of zero means the overlay stays steadily on.
    localparam bit              C_BLINK_EN   = (BLINK_FRAMES > 0);
    localparam logic [CNT_W-1:0] C_BLINK_LAST = C_BLINK_EN ? CNT_W'(BLINK_FRAMES - 1) : '0;
    localparam logic [CNT_W-1:0] C_HOLDOFF    = CNT_W'(HOLDOFF_FRAMES);

    state_t             r_state;
    logic               r_vsync_d;
    logic               r_btn_d;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_phase;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_blink_nx;
    logic [CNT_W-1:0]   w_hold_nx;
    logic               w_phase_nx;
    logic               w_tick;
    logic               w_btn_rise;
    logic               w_ready;

    assign w_tick     = vsync_in & ~r_vsync_d;
    assign w_btn_rise = restart_btn & ~r_btn_d;
    assign w_ready    = (r_hold_cnt == C_HOLDOFF);

    always_comb begin
        w_state_nx = r_state;
        w_blink_nx = r_blink_cnt;
        w_hold_nx  = r_hold_cnt;
        w_phase_nx = r_phase;

        case (r_state)
            S_PLAY: begin
                // Collision wins a tie with the win event. The counters are
                // cleared here so that a tick in the entry cycle is not counted.
                if (collision || win) begin
                    w_state_nx = collision ? S_LOSE : S_WIN;
                    w_blink_nx = '0;
                    w_hold_nx  = '0;
                    w_phase_nx = 1'b1;
                end
            end

            S_LOSE, S_WIN: begin
                if (w_tick) begin
                    if (C_BLINK_EN) begin
                        if (r_blink_cnt == C_BLINK_LAST) begin
                            w_phase_nx = ~r_phase;
                            w_blink_nx = '0;
                        end else begin
                            w_blink_nx = r_blink_cnt + 1'b1;
                        end
                    end
                    if (!w_ready) begin
                        w_hold_nx = r_hold_cnt + 1'b1;
                    end
                end
                // Only a fresh rising edge is accepted, so a button that was
                // already held before the hold-off expired never fires. Edges
                // seen before then are simply dropped.
                if (w_ready && w_btn_rise) begin
                    w_state_nx = S_RESTART;
                end
            end

            default: begin
                w_state_nx = S_PLAY;
            end
        endcase
    end

    // Outputs are decoded from the next-state values. This gives registered
    // Moore outputs that respond on the first cycle after an event.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_PLAY;
            r_vsync_d    <= 1'b0;
            r_btn_d      <= 1'b0;
            r_blink_cnt  <= '0;
            r_hold_cnt   <= '0;
            r_phase      <= 1'b0;
            game_over    <= 1'b0;
            victory      <= 1'b0;
            game_frozen  <= 1'b0;
            game_restart <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_vsync_d    <= vsync_in;
            r_btn_d      <= restart_btn;
            r_blink_cnt  <= w_blink_nx;
            r_hold_cnt   <= w_hold_nx;
            r_phase      <= w_phase_nx;
            game_over    <= (w_state_nx == S_LOSE) & w_phase_nx;
            victory      <= (w_state_nx == S_WIN) & w_phase_nx;
            game_frozen  <= (w_state_nx != S_PLAY);
            game_restart <= (w_state_nx == S_RESTART);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_end_screen_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_end_screen_ctrl
// Description : Directed self-checking bench for end_screen_ctrl. It runs one
//               instance with the default parameters and one with blinking
//               and hold-off disabled. Both instances share the stimulus.
// Revision    : 1.0 - initial release
//============================================================================
module tb_end_screen_ctrl;

    logic       pclk;
    logic       rst;
    logic       vsync_in;
    logic       collision;
    logic       win;
    logic       restart_btn;

    logic       game_over,  victory,  game_frozen,  game_restart;
    logic [1:0] state;
    logic       game_over0, victory0, game_frozen0, game_restart0;
    logic [1:0] state0;

    int n_cmp;
    int n_err;

    end_screen_ctrl dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .collision    (collision),
        .win          (win),
        .restart_btn  (restart_btn),
        .game_over    (game_over),
        .victory      (victory),
        .game_frozen  (game_frozen),
        .game_restart (game_restart),
        .state        (state)
    );

    end_screen_ctrl #(
        .BLINK_FRAMES   (0),
        .HOLDOFF_FRAMES (0),
        .CNT_W          (8)
    ) dut0 (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .collision    (collision),
        .win          (win),
        .restart_btn  (restart_btn),
        .game_over    (game_over0),
        .victory      (victory0),
        .game_frozen  (game_frozen0),
        .game_restart (game_restart0),
        .state        (state0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One frame is three clocks, with a single vsync rising edge.
    task automatic frame();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({state, game_over, victory, game_frozen, game_restart} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {state, game_over, victory, game_frozen, game_restart}, 6'b0);
        end
        step();
        rst = 1'b0;
        step();
        for (int f = 0; f < 5; f++) begin
            frame();
            n_cmp++;
            if ({state, game_over, victory, game_frozen, game_restart} !== 6'b0) begin
                n_err++;
                $display("FAIL play_idle_frame%0d: got %b expected %b", f,
                         {state, game_over, victory, game_frozen, game_restart}, 6'b0);
            end
        end
    endtask

    task automatic test_lose_blink();
        collision = 1'b1;
        step();
        collision = 1'b0;
        n_cmp++;
        if ({state, game_over, victory, game_frozen, game_restart} !== 6'b01_1_0_1_0) begin
            n_err++;
            $display("FAIL lose_entry: got %b expected %b",
                     {state, game_over, victory, game_frozen, game_restart}, 6'b01_1_0_1_0);
        end
        for (int f = 1; f <= 29; f++) frame();
        n_cmp++;
        if (game_over !== 1'b1) begin
            n_err++;
            $display("FAIL lose_tick29_on: got %b expected 1", game_over);
        end
        frame();
        n_cmp++;
        if (game_over !== 1'b0) begin
            n_err++;
            $display("FAIL lose_tick30_off: got %b expected 0", game_over);
        end
        // A collision inside LOSE must not disturb anything.
        collision = 1'b1;
        step();
        collision = 1'b0;
        n_cmp++;
        if (state !== 2'd1 || game_frozen !== 1'b1) begin
            n_err++;
            $display("FAIL lose_ignores_collision: got state=%0d frozen=%b expected 1/1",
                     state, game_frozen);
        end
        for (int f = 31; f <= 60; f++) frame();
        n_cmp++;
        if (game_over !== 1'b1) begin
            n_err++;
            $display("FAIL lose_tick60_on: got %b expected 1", game_over);
        end
    endtask

    task automatic test_mid_reset();
        collision = 1'b1;
        step();
        collision = 1'b0;
        for (int f = 0; f < 35; f++) frame();
        n_cmp++;
        if (state !== 2'd1 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pre: got state=%0d go=%b expected 1/0", state, game_over);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({state, game_over, victory, game_frozen, game_restart} !== 6'b0) begin
            n_err++;
            $display("FAIL midreset_async: got %b expected %b",
                     {state, game_over, victory, game_frozen, game_restart}, 6'b0);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (game_restart !== 1'b0 || state !== 2'd0) begin
                n_err++;
                $display("FAIL midreset_no_pulse%0d: got rs=%b state=%0d expected 0/0",
                         c, game_restart, state);
            end
        end
    endtask

    task automatic test_priority();
        collision = 1'b1;
        win       = 1'b1;
        step();
        collision = 1'b0;
        win       = 1'b0;
        n_cmp++;
        if ({state, game_over, victory, game_frozen} !== 5'b01_1_0_1) begin
            n_err++;
            $display("FAIL priority_lose: got %b expected %b",
                     {state, game_over, victory, game_frozen}, 5'b01_1_0_1);
        end
        for (int f = 0; f < 3; f++) frame();
        n_cmp++;
        if (victory !== 1'b0 || state !== 2'd1) begin
            n_err++;
            $display("FAIL priority_hold: got vi=%b state=%0d expected 0/1", victory, state);
        end
        do_reset();
    endtask

    task automatic test_win_restart();
        win = 1'b1;
        step();
        win = 1'b0;
        n_cmp++;
        if ({state, game_over, victory, game_frozen} !== 5'b10_0_1_1) begin
            n_err++;
            $display("FAIL win_entry: got %b expected %b",
                     {state, game_over, victory, game_frozen}, 5'b10_0_1_1);
        end
        for (int f = 0; f < 10; f++) frame();
        restart_btn = 1'b1;
        step();
        n_cmp++;
        if (state !== 2'd2 || game_restart !== 1'b0) begin
            n_err++;
            $display("FAIL win_early_press: got state=%0d rs=%b expected 2/0", state, game_restart);
        end
        for (int f = 10; f < 65; f++) frame();
        n_cmp++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL win_held_btn: got state=%0d expected 2", state);
        end
        restart_btn = 1'b0;
        step();
        restart_btn = 1'b1;
        step();
        n_cmp++;
        if ({state, victory, game_frozen, game_restart} !== 5'b11_0_1_1) begin
            n_err++;
            $display("FAIL win_restart_pulse: got %b expected %b",
                     {state, victory, game_frozen, game_restart}, 5'b11_0_1_1);
        end
        // Events seen during RESTART are ignored.
        collision = 1'b1;
        step();
        collision = 1'b0;
        n_cmp++;
        if ({state, game_frozen, game_restart} !== 4'b00_0_0) begin
            n_err++;
            $display("FAIL win_back_to_play: got %b expected %b",
                     {state, game_frozen, game_restart}, 4'b0);
        end
        step();
        n_cmp++;
        if ({state, game_frozen, game_restart} !== 4'b00_0_0) begin
            n_err++;
            $display("FAIL win_stays_play: got %b expected %b",
                     {state, game_frozen, game_restart}, 4'b0);
        end
        restart_btn = 1'b0;
        step();
    endtask

    task automatic test_no_blink_no_holdoff();
        do_reset();
        win = 1'b1;
        step();
        win = 1'b0;
        n_cmp++;
        if (state0 !== 2'd2 || victory0 !== 1'b1) begin
            n_err++;
            $display("FAIL nb_entry: got state=%0d vi=%b expected 2/1", state0, victory0);
        end
        for (int f = 0; f < 4; f++) begin
            frame();
            n_cmp++;
            if (victory0 !== 1'b1) begin
                n_err++;
                $display("FAIL nb_steady%0d: got %b expected 1", f, victory0);
            end
        end
        restart_btn = 1'b1;
        step();
        n_cmp++;
        if (state0 !== 2'd3 || game_restart0 !== 1'b1 || victory0 !== 1'b0) begin
            n_err++;
            $display("FAIL nb_restart: got state=%0d rs=%b vi=%b expected 3/1/0",
                     state0, game_restart0, victory0);
        end
        // The default instance is still in hold-off and must ignore the press.
        n_cmp++;
        if (state !== 2'd2 || game_restart !== 1'b0) begin
            n_err++;
            $display("FAIL nb_default_holdoff: got state=%0d rs=%b expected 2/0",
                     state, game_restart);
        end
        step();
        n_cmp++;
        if (state0 !== 2'd0 || game_restart0 !== 1'b0 || game_frozen0 !== 1'b0) begin
            n_err++;
            $display("FAIL nb_play: got state=%0d rs=%b fr=%b expected 0/0/0",
                     state0, game_restart0, game_frozen0);
        end
        restart_btn = 1'b0;
        step();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        vsync_in    = 1'b0;
        collision   = 1'b0;
        win         = 1'b0;
        restart_btn = 1'b0;
        #3;
        test_reset();
        test_lose_blink();
        do_reset();
        test_mid_reset();
        test_priority();
        test_win_restart();
        test_no_blink_no_holdoff();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
